mem_access_way0: RTL and testbench
==================================

MEM_ACCESS_WAY0 -- requirements
Module: mem_access_way0

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 0, meaning the cycle count after which an unanswered RAM request is abandoned; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port valid_i, input, 1 bit: upstream op valid.
REQ-005 SHALL have port ready_o, output, 1 bit: op accepted when valid_i and ready_o are both high.
REQ-006 SHALL have ports memRead_i and memWrite_i, input, 1 bit each: op class flags.
REQ-007 SHALL have ports rdWriteEnable_i (1), rdAddr_i (5), rdData_i (64), funct3_i (3), all input: writeback payload.
REQ-008 SHALL have ports memAddr_i (32), writeData_i (64), writeMask_i (8), all input: memory payload.
REQ-009 SHALL have RAM ports: ramReadEn_o (1) out, ramWriteEn_o (1) out, ramAddr_o (32) out, ramWriteData_o (64) out, ramWriteMask_o (8) out, ramReadData_i (64) in, dataOk_i (1) in (read done), writeDone_i (1) in (write done).
REQ-010 SHALL have writeback ports: wbValid_o (1) out, wbReady_i (1) in, wbRdWriteEnable_o (1) out, wbRdAddr_o (5) out, wbRdData_o (64) out, timeout_o (1) out.

Function
REQ-011 SHALL implement the FSM states IDLE, READ, WRITE and RESP.
REQ-012 SHALL drive ready_o high only in IDLE, combinationally.
REQ-013 SHALL register all inputs on acceptance; none are sampled again until the FSM next returns to IDLE.
REQ-014 SHALL transition on acceptance as follows: memRead_i -> READ; memWrite_i -> WRITE (only if memRead_i is low); neither -> RESP. If both flags are set, the read SHALL win.
REQ-015 SHALL in READ hold ramReadEn_o=1 with the registered ramAddr_o; on dataOk_i go to RESP.
REQ-016 SHALL in WRITE hold ramWriteEn_o=1 with the registered address, data and mask; on writeDone_i go to RESP.
REQ-017 SHALL accept a dataOk_i or writeDone_i that arrives in the first request cycle, giving minimum latency acceptance -> wbValid_o = 2 cycles for memory ops and 1 cycle for non-memory ops.
REQ-018 SHALL in RESP hold wbValid_o=1 with stable payload until wbReady_i; on wbValid_o and wbReady_i both high go to IDLE. A new op SHALL NOT be accepted in the same cycle.
REQ-019 SHALL form load data from the beat captured on dataOk_i, using byte offset memAddr[2:0] aligned down to the access size, selected by funct3:
 - 000 LB, 001 LH, 010 LW and 011 LD: sign-extend.
 - 100 LBU, 101 LHU and 110 LWU: zero-extend.
 - 111: result 0.
REQ-020 SHALL pass rdData_i through for non-memory ops, and SHALL force wbRdWriteEnable_o=0 for stores.
REQ-021 SHALL force wbRdWriteEnable_o=0 whenever rdAddr is 0.
REQ-022 SHALL, when RESP_TIMEOUT>0, abandon a READ or WRITE after RESP_TIMEOUT cycles without completion: go to RESP, set wbRdWriteEnable_o=0, and set timeout_o=1 for the whole RESP phase.
REQ-023 SHALL ignore dataOk_i and writeDone_i in all states other than the matching READ or WRITE state.

Reset
REQ-024 SHALL on reset_n low immediately return the FSM to IDLE and clear every output and register: ready_o is then 1, and every other output is 0.
REQ-025 SHALL treat reset asserted mid-transaction as dropping that transaction, with no writeback.
REQ-026 SHALL resume normal operation on the first rising clk edge after reset_n is released.

Structure
REQ-027 SHALL place the state enum and the funct3 load encodings in the shared core package.
REQ-028 SHALL implement load alignment and extension as the combinational sub-module load_extend (inputs: 64-bit beat, offset[2:0], funct3; output: 64-bit result).
REQ-029 SHALL contain exactly one timeout counter, sized to RESP_TIMEOUT.

Verification
REQ-030 Non-memory op rdAddr=5, rdData=0x1234 with wbReady_i=1 -> wbValid_o high one cycle after acceptance, carrying wbRdAddr_o=5 and wbRdData_o=0x1234.
REQ-031 LB at memAddr 0x1003 with ramReadData_i=0x00000000_80000000 and dataOk_i one cycle later -> wbRdData_o=0xFFFFFFFF_FFFFFF80; LBU of the same beat -> 0x80.
REQ-032 SD with mask 0xFF and writeDone_i held low for 5 cycles -> ramWriteEn_o and the payload stay stable throughout; then wbValid_o=1 with wbRdWriteEnable_o=0.
REQ-033 wbReady_i held low for 3 cycles in RESP -> wbValid_o and the payload stay stable and ready_o stays 0; the next op is accepted only after the handshake.
REQ-034 reset_n pulsed low during READ -> outputs clear asynchronously, no writeback occurs, and ready_o=1 after release.
REQ-035 RESP_TIMEOUT=4 with no dataOk_i -> RESP entered after 4 cycles with timeout_o=1 and wbRdWriteEnable_o=0.

Source files
------------

// File: rtl/mem_access_way0_pkg.sv
// Shared definitions for the way-0 memory access stage: FSM states and
// the funct3 load encodings used by the load alignment logic.
package mem_access_way0_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_NOP = 3'b111;

endpackage

// File: rtl/mem_access_way0_load_extend.sv
// Load alignment and extension: picks the addressed element out of a
// 64-bit beat (offset aligned down to the access size) and sign- or
// zero-extends it according to funct3.
module load_extend
  import mem_access_way0_pkg::*;
(
  input  logic [63:0] i_beat,
  input  logic [2:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_result
);

  logic [2:0]  w_offset;
  logic [63:0] w_shifted;

  // Align the byte offset down to the natural boundary of the access size
  always_comb begin
    w_offset = 3'd0;
    case (i_funct3[1:0])
      2'b00:   w_offset = i_offset;
      2'b01:   w_offset = {i_offset[2:1], 1'b0};
      2'b10:   w_offset = {i_offset[2], 2'b00};
      default: w_offset = 3'd0;
    endcase
  end

  assign w_shifted = i_beat >> {w_offset, 3'b000};

  // Extend the selected element to 64 bits
  always_comb begin
    o_result = 64'd0;
    case (i_funct3)
      F3_LB:   o_result = {{56{w_shifted[7]}},  w_shifted[7:0]};
      F3_LH:   o_result = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   o_result = w_shifted;
      F3_LBU:  o_result = {56'd0, w_shifted[7:0]};
      F3_LHU:  o_result = {48'd0, w_shifted[15:0]};
      F3_LWU:  o_result = {32'd0, w_shifted[31:0]};
      F3_NOP:  o_result = 64'd0;
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_way0.sv
// Way-0 memory access stage: accepts one op at a time, performs the RAM
// read or write it needs, then holds the writeback result until the
// consumer takes it. An optional timeout abandons a RAM request that is
// never answered.
module mem_access_way0
  import mem_access_way0_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic        rdWriteEnable_i,
  input  logic [4:0]  rdAddr_i,
  input  logic [63:0] rdData_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] memAddr_i,
  input  logic [63:0] writeData_i,
  input  logic [7:0]  writeMask_i,
  output logic        ramReadEn_o,
  output logic        ramWriteEn_o,
  output logic [31:0] ramAddr_o,
  output logic [63:0] ramWriteData_o,
  output logic [7:0]  ramWriteMask_o,
  input  logic [63:0] ramReadData_i,
  input  logic        dataOk_i,
  input  logic        writeDone_i,
  output logic        wbValid_o,
  input  logic        wbReady_i,
  output logic        wbRdWriteEnable_o,
  output logic [4:0]  wbRdAddr_o,
  output logic [63:0] wbRdData_o,
  output logic        timeout_o
);

  // Counter holds 0 .. RESP_TIMEOUT-1; keep at least one bit when disabled
  localparam int unsigned TO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((RESP_TIMEOUT > 0) ? (RESP_TIMEOUT - 1) : 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [31:0]       r_mem_addr;
  logic [63:0]       r_write_data;
  logic [7:0]        r_write_mask;
  logic [4:0]        r_rd_addr;
  logic [2:0]        r_funct3;
  logic              r_rd_we;
  logic [63:0]       r_wb_data;
  logic              r_timeout;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_to_expire;
  logic              w_is_store;
  logic [63:0]       w_load_data;

  assign w_to_expire = (RESP_TIMEOUT > 0) && (r_to_cnt == TO_LAST);
  assign w_is_store  = memWrite_i && !memRead_i;

  load_extend u_load_extend (
    .i_beat   (ramReadData_i),
    .i_offset (r_mem_addr[2:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a read wins when both class flags are set
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          if (memRead_i) begin
            w_state_nxt = READ;
          end else if (memWrite_i) begin
            w_state_nxt = WRITE;
          end else begin
            w_state_nxt = RESP;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        if (dataOk_i || w_to_expire) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = READ;
        end
      end
      WRITE: begin
        if (writeDone_i || w_to_expire) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      RESP: begin
        if (wbReady_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the accepted op, the load result and the timeout status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr   <= 32'd0;
      r_write_data <= 64'd0;
      r_write_mask <= 8'd0;
      r_rd_addr    <= 5'd0;
      r_funct3     <= 3'd0;
      r_rd_we      <= 1'b0;
      r_wb_data    <= 64'd0;
      r_timeout    <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_mem_addr   <= memAddr_i;
            r_write_data <= writeData_i;
            r_write_mask <= writeMask_i;
            r_rd_addr    <= rdAddr_i;
            r_funct3     <= funct3_i;
            // x0 is never written and stores have no register result
            r_rd_we      <= rdWriteEnable_i && (rdAddr_i != 5'd0) && !w_is_store;
            r_wb_data    <= (memRead_i || memWrite_i) ? 64'd0 : rdData_i;
            r_timeout    <= 1'b0;
            r_to_cnt     <= '0;
          end
        end
        READ: begin
          if (dataOk_i) begin
            r_wb_data <= w_load_data;
          end else if (w_to_expire) begin
            r_rd_we   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        WRITE: begin
          if (writeDone_i) begin
            r_timeout <= 1'b0;
          end else if (w_to_expire) begin
            r_rd_we   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          if (wbReady_i) begin
            r_timeout <= 1'b0;
          end
        end
        default: begin
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o           = (r_state == IDLE);
  assign ramReadEn_o       = (r_state == READ);
  assign ramWriteEn_o      = (r_state == WRITE);
  assign ramAddr_o         = r_mem_addr;
  assign ramWriteData_o    = r_write_data;
  assign ramWriteMask_o    = r_write_mask;
  assign wbValid_o         = (r_state == RESP);
  assign wbRdWriteEnable_o = r_rd_we;
  assign wbRdAddr_o        = r_rd_addr;
  assign wbRdData_o        = r_wb_data;
  assign timeout_o         = r_timeout;

endmodule

// File: tb/tb_mem_access_way0.sv
// Bench for mem_access_way0: directed cases plus randomized ops, with a
// scoreboard queue filled at issue time and drained by a writeback monitor.
module tb_mem_access_way0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i, memRead_i, memWrite_i, rdWriteEnable_i;
  logic [4:0]  rdAddr_i;
  logic [63:0] rdData_i;
  logic [2:0]  funct3_i;
  logic [31:0] memAddr_i;
  logic [63:0] writeData_i;
  logic [7:0]  writeMask_i;
  logic        ready_o, ramReadEn_o, ramWriteEn_o;
  logic [31:0] ramAddr_o;
  logic [63:0] ramWriteData_o;
  logic [7:0]  ramWriteMask_o;
  logic [63:0] ramReadData_i;
  logic        dataOk_i, writeDone_i;
  logic        wbValid_o, wbReady_i, wbRdWriteEnable_o;
  logic [4:0]  wbRdAddr_o;
  logic [63:0] wbRdData_o;
  logic        timeout_o;

  // timeout-enabled instance
  logic        t_valid, t_memRead, t_wbReady;
  logic        t_ready, t_ramReadEn, t_ramWriteEn, t_wbValid, t_wbWe, t_timeout;
  logic [31:0] t_ramAddr;
  logic [63:0] t_ramWriteData, t_wbData;
  logic [7:0]  t_ramWriteMask;
  logic [4:0]  t_wbRdAddr;

  logic rdy_rand, rdy_force;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        to;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access_way0 dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i),
    .rdWriteEnable_i(rdWriteEnable_i), .rdAddr_i(rdAddr_i), .rdData_i(rdData_i),
    .funct3_i(funct3_i), .memAddr_i(memAddr_i), .writeData_i(writeData_i),
    .writeMask_i(writeMask_i), .ramReadEn_o(ramReadEn_o), .ramWriteEn_o(ramWriteEn_o),
    .ramAddr_o(ramAddr_o), .ramWriteData_o(ramWriteData_o), .ramWriteMask_o(ramWriteMask_o),
    .ramReadData_i(ramReadData_i), .dataOk_i(dataOk_i), .writeDone_i(writeDone_i),
    .wbValid_o(wbValid_o), .wbReady_i(wbReady_i), .wbRdWriteEnable_o(wbRdWriteEnable_o),
    .wbRdAddr_o(wbRdAddr_o), .wbRdData_o(wbRdData_o), .timeout_o(timeout_o)
  );

  mem_access_way0 #(.RESP_TIMEOUT(4)) dut_t (
    .clk(clk), .reset_n(reset_n), .valid_i(t_valid), .ready_o(t_ready),
    .memRead_i(t_memRead), .memWrite_i(1'b0),
    .rdWriteEnable_i(1'b1), .rdAddr_i(5'd7), .rdData_i(64'h55),
    .funct3_i(3'b011), .memAddr_i(32'h40), .writeData_i(64'd0),
    .writeMask_i(8'd0), .ramReadEn_o(t_ramReadEn), .ramWriteEn_o(t_ramWriteEn),
    .ramAddr_o(t_ramAddr), .ramWriteData_o(t_ramWriteData), .ramWriteMask_o(t_ramWriteMask),
    .ramReadData_i(64'hFFFF), .dataOk_i(1'b0), .writeDone_i(1'b0),
    .wbValid_o(t_wbValid), .wbReady_i(t_wbReady), .wbRdWriteEnable_o(t_wbWe),
    .wbRdAddr_o(t_wbRdAddr), .wbRdData_o(t_wbData), .timeout_o(t_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Writeback consumer readiness, changed mid-cycle away from both edges
  always @(posedge clk) begin
    #2;
    wbReady_i = rdy_rand ? 1'($urandom % 2) : rdy_force;
  end

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference load result from the size/offset/extension rules
  function automatic logic [63:0] ref_load(input logic [63:0] beat, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int sz, off;
    logic [63:0] v, m;
    if (f3 == 3'b111) return 64'd0;
    sz  = 1 << f3[1:0];
    off = (int'(addr[2:0]) / sz) * sz;
    v   = beat >> (8 * off);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (!f3[2] && v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  // Writeback monitor: every handshake must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && wbValid_o && wbReady_i) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h with nothing expected",
                 wbRdAddr_o, wbRdData_o);
      end else begin
        mon_e = sb_q.pop_front();
        if ({wbRdAddr_o, wbRdWriteEnable_o, wbRdData_o, timeout_o} !==
            {mon_e.rd, mon_e.we, mon_e.data, mon_e.to}) begin
          n_fail++;
          $display("FAIL wb_payload: got rd=%0d we=%b data=%h to=%b expected rd=%0d we=%b data=%h to=%b",
                   wbRdAddr_o, wbRdWriteEnable_o, wbRdData_o, timeout_o,
                   mon_e.rd, mon_e.we, mon_e.data, mon_e.to);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) chk("ready_wait", {191'd0, ready_o}, 192'd1);
  endtask

  task automatic issue_op(input logic mr, input logic mw, input logic we, input logic [4:0] rd,
                          input logic [63:0] rdd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] beat,
                          input int lat);
    exp_t e;
    wait_ready();
    valid_i = 1'b1; memRead_i = mr; memWrite_i = mw; rdWriteEnable_i = we;
    rdAddr_i = rd; rdData_i = rdd; funct3_i = f3; memAddr_i = addr;
    writeData_i = wd; writeMask_i = wm;
    e.rd = rd;
    e.to = 1'b0;
    if (mr) begin
      e.we = we && (rd != 5'd0); e.data = ref_load(beat, addr, f3);
    end else if (mw) begin
      e.we = 1'b0; e.data = 64'd0;
    end else begin
      e.we = we && (rd != 5'd0); e.data = rdd;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0; memRead_i = 1'($urandom); memWrite_i = 1'($urandom);
    rdWriteEnable_i = 1'($urandom); rdAddr_i = 5'($urandom); rdData_i = {$urandom, $urandom};
    funct3_i = 3'($urandom); memAddr_i = $urandom; writeData_i = {$urandom, $urandom};
    writeMask_i = 8'($urandom);
    if (mr) begin
      for (int i = 0; i <= lat; i++) begin
        chk("rd_req", {ramReadEn_o, ramWriteEn_o, ramAddr_o}, {1'b1, 1'b0, addr});
        writeDone_i = 1'($urandom);
        dataOk_i = (i == lat);
        ramReadData_i = (i == lat) ? beat : {$urandom, $urandom};
        @(posedge clk); #1;
      end
      chk("lat_mem", {191'd0, wbValid_o}, 192'd1);
    end else if (mw) begin
      for (int i = 0; i <= lat; i++) begin
        chk("wr_req", {ramWriteEn_o, ramReadEn_o, ramAddr_o, ramWriteData_o, ramWriteMask_o},
            {1'b1, 1'b0, addr, wd, wm});
        dataOk_i = 1'($urandom);
        writeDone_i = (i == lat);
        @(posedge clk); #1;
      end
      chk("lat_mem", {191'd0, wbValid_o}, 192'd1);
    end else begin
      chk("lat_nonmem", {191'd0, wbValid_o}, 192'd1);
    end
    dataOk_i = 1'b0; writeDone_i = 1'b0; ramReadData_i = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] hold_d;
    int n;
    reset_n = 1'b0; valid_i = 1'b0; memRead_i = 1'b0; memWrite_i = 1'b0;
    rdWriteEnable_i = 1'b0; rdAddr_i = 5'd0; rdData_i = 64'd0; funct3_i = 3'd0;
    memAddr_i = 32'd0; writeData_i = 64'd0; writeMask_i = 8'd0;
    ramReadData_i = 64'd0; dataOk_i = 1'b0; writeDone_i = 1'b0; wbReady_i = 1'b0;
    t_valid = 1'b0; t_memRead = 1'b0; t_wbReady = 1'b0;
    rdy_rand = 1'b0; rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_main", {ready_o, ramReadEn_o, ramWriteEn_o, ramAddr_o, ramWriteData_o, ramWriteMask_o,
                       wbValid_o, wbRdWriteEnable_o, wbRdAddr_o, wbRdData_o, timeout_o},
        {1'b1, 178'd0});
    chk("reset_tmo", {t_ready, t_ramReadEn, t_ramWriteEn, t_ramAddr, t_ramWriteData, t_ramWriteMask,
                      t_wbValid, t_wbWe, t_wbRdAddr, t_wbData, t_timeout},
        {1'b1, 178'd0});
    reset_n = 1'b1;
    @(posedge clk); #1;

    // non-memory passthrough
    issue_op(1'b0, 1'b0, 1'b1, 5'd5, 64'h1234, 3'd0, 32'd0, 64'd0, 8'd0, 64'd0, 0);
    wait_ready();
    // LB / LBU of a byte with its top bit set
    issue_op(1'b1, 1'b0, 1'b1, 5'd3, 64'hDEAD, 3'b000, 32'h1003, 64'd0, 8'd0, 64'h0000_0000_8000_0000, 1);
    issue_op(1'b1, 1'b0, 1'b1, 5'd3, 64'hDEAD, 3'b100, 32'h1003, 64'd0, 8'd0, 64'h0000_0000_8000_0000, 1);
    // SD with slow completion
    issue_op(1'b0, 1'b1, 1'b1, 5'd9, 64'd0, 3'b011, 32'h2000, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'd0, 5);
    // both flags: read must win
    issue_op(1'b1, 1'b1, 1'b1, 5'd4, 64'd0, 3'b011, 32'h3000, 64'h1, 8'h1, 64'hA5A5_0000_1111_2222, 0);
    // rd = x0 never writes back
    issue_op(1'b0, 1'b0, 1'b1, 5'd0, 64'h77, 3'd0, 32'd0, 64'd0, 8'd0, 64'd0, 0);
    wait_ready();

    // consumer stalls three cycles in RESP
    rdy_force = 1'b0;
    @(posedge clk); #1;
    hold_d = {$urandom, $urandom};
    issue_op(1'b0, 1'b0, 1'b1, 5'd12, hold_d, 3'd0, 32'd0, 64'd0, 8'd0, 64'd0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("resp_hold", {wbValid_o, ready_o, wbRdAddr_o, wbRdData_o}, {1'b1, 1'b0, 5'd12, hold_d});
      @(posedge clk); #1;
    end
    rdy_force = 1'b1;
    wait_ready();
    issue_op(1'b0, 1'b0, 1'b1, 5'd13, 64'h99, 3'd0, 32'd0, 64'd0, 8'd0, 64'd0, 0);
    wait_ready();

    // reset in the middle of a read drops it
    valid_i = 1'b1; memRead_i = 1'b1; memWrite_i = 1'b0; rdWriteEnable_i = 1'b1;
    rdAddr_i = 5'd4; funct3_i = 3'b011; memAddr_i = 32'h5008;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("rst_pre", {191'd0, ramReadEn_o}, 192'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {ready_o, ramReadEn_o, ramWriteEn_o, ramAddr_o, ramWriteData_o, ramWriteMask_o,
                      wbValid_o, wbRdWriteEnable_o, wbRdAddr_o, wbRdData_o, timeout_o},
        {1'b1, 178'd0});
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_wb", {190'd0, wbValid_o, ready_o}, 192'd1);
    end

    // timeout instance: read never answered
    t_valid = 1'b1; t_memRead = 1'b1; t_wbReady = 1'b0;
    @(posedge clk); #1;
    t_valid = 1'b0; t_memRead = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("to_wait", {191'd0, t_wbValid}, {191'd0, (i == 4)});
    end
    chk("to_flags", {189'd0, t_timeout, t_wbWe, t_ramReadEn}, {189'd0, 3'b100});
    @(posedge clk); #1;
    chk("to_hold", {190'd0, t_timeout, t_wbValid}, {190'd0, 2'b11});
    t_wbReady = 1'b1;
    @(posedge clk); #1;
    chk("to_done", {189'd0, t_ready, t_timeout, t_wbValid}, {189'd0, 3'b100});

    // randomized traffic
    rdy_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int kind;
      kind = $urandom % 4;
      issue_op(1'(kind == 1 || kind == 3), 1'(kind == 2 || kind == 3), 1'($urandom),
               (($urandom % 4) == 0) ? 5'd0 : 5'($urandom), {$urandom, $urandom},
               3'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
               {$urandom, $urandom}, int'($urandom % 4));
    end
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drain", 192'(sb_q.size()), 192'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
